// File: rtl/pulse_record_buffer_pkg.sv
// Shared widths for the lighthouse record path (vive_tracker_defs) and the record layout.
package pulse_record_buffer_pkg;
    localparam int DECODED_W   = 17;
    localparam int TIMESTAMP_W = 24;
    localparam int RECORD_W    = DECODED_W + TIMESTAMP_W;
    localparam int OVF_CNT_W   = 8;

    typedef struct packed {
        logic [DECODED_W-1:0]   data;
        logic [TIMESTAMP_W-1:0] ts;
    } record_t;

    function automatic record_t make_record(input logic [DECODED_W-1:0] d,
                                            input logic [TIMESTAMP_W-1:0] t);
        record_t r;
        r.data = d;
        r.ts   = t;
        return r;
    endfunction
endpackage

// File: rtl/pulse_record_buffer_if.sv
// Capture and readout signals of the pulse record buffer.
// PULSE_BUFFER_OVF_COUNT_EN adds the saturating overflow_count output.
interface pulse_record_buffer_if
    import pulse_record_buffer_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                   data_availible;
    logic [DECODED_W-1:0]   decoded_data;
    logic [TIMESTAMP_W-1:0] timestamp_last_data;
    logic                   rd_en;
    logic                   clear_overflow;
    logic [RECORD_W-1:0]    rd_data;
    logic                   rd_valid;
    logic [ADDR_W:0]        level;
    logic                   full;
    logic                   overflow;
`ifdef PULSE_BUFFER_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0]   overflow_count;
`endif

    modport master (
        output data_availible, decoded_data, timestamp_last_data, rd_en, clear_overflow,
`ifdef PULSE_BUFFER_OVF_COUNT_EN
        input  overflow_count,
`endif
        input  rd_data, rd_valid, level, full, overflow
    );

    modport slave (
        input  data_availible, decoded_data, timestamp_last_data, rd_en, clear_overflow,
`ifdef PULSE_BUFFER_OVF_COUNT_EN
        output overflow_count,
`endif
        output rd_data, rd_valid, level, full, overflow
    );
endinterface

// File: rtl/pulse_record_buffer_mem.sv
// Record storage: one synchronous write port, one asynchronous read port, contents never cleared.
module pulse_fifo_mem
    import pulse_record_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [RECORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [RECORD_W-1:0] rdata_o
);
    logic [RECORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pulse_record_buffer.sv
// FWFT buffer of decoded lighthouse words with drop-newest on full and a sticky overflow flag.
// PULSE_BUFFER_OVF_COUNT_EN adds a saturating dropped-record counter.
module pulse_record_buffer
    import pulse_record_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic                  clk_96MHz,
    input logic                  reset,
    pulse_record_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
    logic                da_q, ovf_q, ovf_d;
    logic                push, pop, empty, is_full, wr_en, drop;
    logic [RECORD_W-1:0] mem_rdata;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (level == '0);
    assign is_full = (level == DEPTH_L);
    assign push    = bus.data_availible & ~da_q;
    assign pop     = bus.rd_en & ~empty;
    // A simultaneous pop frees the slot, so a push into a full buffer still lands.
    assign wr_en   = push & (~is_full | pop);
    assign drop    = push & is_full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_en);
        rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(pop);
        ovf_d    = ovf_q;
        if (bus.clear_overflow) ovf_d = 1'b0;
        if (drop)               ovf_d = 1'b1;
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            // Start high so a level already asserted at reset release is not a new word.
            da_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            da_q     <= bus.data_availible;
        end
    end

    pulse_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk_i   (clk_96MHz),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (make_record(bus.decoded_data, bus.timestamp_last_data)),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (mem_rdata)
    );

    assign bus.rd_data  = empty ? '0 : mem_rdata;
    assign bus.rd_valid = ~empty;
    assign bus.level    = level;
    assign bus.full     = is_full;
    assign bus.overflow = ovf_q;

`ifdef PULSE_BUFFER_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (bus.clear_overflow)  ovf_cnt_d = OVF_CNT_W'(drop);
        else if (drop && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign bus.overflow_count = ovf_cnt_q;
`endif
endmodule
